// File: rtl/weighted_run_encoder.sv
// weighted_run_encoder
//   Run-length encodes the voted bit stream into (level, length) tokens and
//   queues them in a small FIFO behind a valid/ready output.
//
//   Ports
//     clk, rst        : clock, synchronous active-high reset
//     in_valid/in_bit : voted sample strobe and value
//     flush           : close the open run (only honoured when in_valid=0)
//     tok_valid/ready : token handshake; pop on valid & ready
//     tok_level/len   : head token (both zero when the FIFO is empty)
//     fifo_count      : number of stored tokens
//     overflow        : sticky drop flag, present only when the macro
//                       WEIGHTED_RUN_OVERFLOW_EN is defined
module weighted_run_encoder #(
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          in_bit,
  input  logic                          flush,
  output logic                          tok_valid,
  input  logic                          tok_ready,
  output logic                          tok_level,
  output logic [LEN_W-1:0]              tok_len,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef WEIGHTED_RUN_OVERFLOW_EN
  ,
  output logic                          overflow
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q;
  logic             cur_level_q;
  logic [LEN_W-1:0] run_len_q;

  logic             push_d;
  logic             push_level_d;
  logic [LEN_W-1:0] push_len_d;

  logic             lvl_mem [FIFO_DEPTH];
  logic [LEN_W-1:0] len_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic full;
  logic pop;
  logic push_ok;

  // A token is emitted when an open run is closed: by a level change, by
  // reaching the maximum length (saturate-and-split), or by a lone flush.
  // In every case the closed run is exactly (cur_level_q, run_len_q).
  always_comb begin
    push_d       = 1'b0;
    push_level_d = cur_level_q;
    push_len_d   = run_len_q;
    if (state_q == RUN) begin
      if (in_valid) begin
        if ((in_bit != cur_level_q) || (run_len_q == LEN_MAX)) begin
          push_d = 1'b1;
        end
      end else if (flush) begin
        push_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_level_q <= 1'b0;
      run_len_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q     <= RUN;
            cur_level_q <= in_bit;
            run_len_q   <= LEN_W'(1);
          end
        end
        RUN: begin
          if (in_valid) begin
            if ((in_bit != cur_level_q) || (run_len_q == LEN_MAX)) begin
              cur_level_q <= in_bit;
              run_len_q   <= LEN_W'(1);
            end else begin
              run_len_q <= run_len_q + LEN_W'(1);
            end
          end else if (flush) begin
            state_q   <= IDLE;
            run_len_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop     = tok_valid & tok_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted when the head is being consumed.
  assign push_ok = push_d & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      lvl_mem[wr_ptr_q] <= push_level_d;
      len_mem[wr_ptr_q] <= push_len_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef WEIGHTED_RUN_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push_d && !push_ok) begin
      overflow <= 1'b1;
    end
  end
`endif

  assign tok_valid  = (count_q != '0);
  assign tok_level  = tok_valid ? lvl_mem[rd_ptr_q] : 1'b0;
  assign tok_len    = tok_valid ? len_mem[rd_ptr_q] : '0;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_weighted_run_encoder.sv
module tb_weighted_run_encoder;

  localparam int DEPTH = 4;
  localparam int LMAX  = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, in_valid = 1'b0, in_bit = 1'b0, flush = 1'b0, tok_ready = 1'b1;

  logic       tok_valid, tok_level;
  logic [7:0] tok_len;
  logic [2:0] fifo_count;
  logic       t3_valid, t3_level;
  logic [2:0] t3_len;
  logic [2:0] t3_count;
`ifdef WEIGHTED_RUN_OVERFLOW_EN
  logic ovf, ovf3;
`endif

  weighted_run_encoder #(.LEN_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .flush(flush),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_level(tok_level),
    .tok_len(tok_len), .fifo_count(fifo_count)
`ifdef WEIGHTED_RUN_OVERFLOW_EN
    , .overflow(ovf)
`endif
  );

  weighted_run_encoder #(.LEN_W(3), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .flush(flush),
    .tok_valid(t3_valid), .tok_ready(tok_ready), .tok_level(t3_level),
    .tok_len(t3_len), .fifo_count(t3_count)
`ifdef WEIGHTED_RUN_OVERFLOW_EN
    , .overflow(ovf3)
`endif
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: open run plus token queue, updated per clock edge.
  bit m_open;
  bit m_lvl;
  int m_len;
  bit m_ovf;
  int mq_lvl[$];
  int mq_len[$];
  bit started = 0;

  always @(posedge clk) begin
    bit pu;
    bit po;
    int pl;
    int pn;
    started = 1;
    if (rst) begin
      m_open = 0; m_lvl = 0; m_len = 0; m_ovf = 0;
      mq_lvl.delete(); mq_len.delete();
    end else begin
      pu = 0; pl = 0; pn = 0;
      po = (mq_lvl.size() != 0) && tok_ready;
      if (in_valid) begin
        if (!m_open) begin
          m_open = 1; m_lvl = in_bit; m_len = 1;
        end else if (in_bit == m_lvl) begin
          if (m_len == LMAX) begin
            pu = 1; pl = m_lvl; pn = LMAX; m_len = 1;
          end else begin
            m_len++;
          end
        end else begin
          pu = 1; pl = m_lvl; pn = m_len; m_lvl = in_bit; m_len = 1;
        end
      end else if (flush && m_open) begin
        pu = 1; pl = m_lvl; pn = m_len; m_open = 0;
      end
      if (po) begin
        void'(mq_lvl.pop_front());
        void'(mq_len.pop_front());
      end
      if (pu) begin
        if (mq_lvl.size() < DEPTH) begin
          mq_lvl.push_back(pl);
          mq_len.push_back(pn);
        end else begin
          m_ovf = 1;
        end
      end
    end
  end

  // Tokens observed leaving each DUT (pop happens at the next rising edge).
  int log_l[$];
  int log_n[$];
  int log3_l[$];
  int log3_n[$];

  always @(negedge clk) begin
    if (started) begin
      chk("tok_valid", 32'(tok_valid), 32'(mq_lvl.size() != 0));
      chk("fifo_count", 32'(fifo_count), 32'(mq_lvl.size()));
      chk("tok_level", 32'(tok_level), (mq_lvl.size() != 0) ? 32'(mq_lvl[0]) : 32'd0);
      chk("tok_len", 32'(tok_len), (mq_len.size() != 0) ? 32'(mq_len[0]) : 32'd0);
`ifdef WEIGHTED_RUN_OVERFLOW_EN
      chk("overflow", 32'(ovf), 32'(m_ovf));
`endif
      if (!rst && tok_valid && tok_ready) begin
        log_l.push_back(int'(tok_level));
        log_n.push_back(int'(tok_len));
      end
      if (!rst && t3_valid && tok_ready) begin
        log3_l.push_back(int'(t3_level));
        log3_n.push_back(int'(t3_len));
      end
    end
  end

  task automatic step(input logic v, input logic b, input logic f);
    in_valid = v; in_bit = b; flush = f;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_logs;
    log_l.delete(); log_n.delete(); log3_l.delete(); log3_n.delete();
  endtask

  task automatic do_reset;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic exp_tok(input string nm, input int idx, input int l, input int n);
    chk({nm, "_level"}, (idx < log_l.size()) ? 32'(log_l[idx]) : 32'hFFFF_FFFF, 32'(l));
    chk({nm, "_len"},   (idx < log_n.size()) ? 32'(log_n[idx]) : 32'hFFFF_FFFF, 32'(n));
  endtask

  task automatic exp_tok3(input string nm, input int idx, input int l, input int n);
    chk({nm, "_level"}, (idx < log3_l.size()) ? 32'(log3_l[idx]) : 32'hFFFF_FFFF, 32'(l));
    chk({nm, "_len"},   (idx < log3_n.size()) ? 32'(log3_n[idx]) : 32'hFFFF_FFFF, 32'(n));
  endtask

  initial begin
    rst = 1'b1; tok_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid", 32'(tok_valid), 32'd0);
    chk("rst_level", 32'(tok_level), 32'd0);
    chk("rst_len", 32'(tok_len), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
`ifdef WEIGHTED_RUN_OVERFLOW_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    clear_logs();

    // Basic runs: 4x0, 5x1, 6x0, flush.
    repeat (4) step(1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b1, 1'b0);
    repeat (6) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(3);
    chk("t1_ntok", 32'(log_l.size()), 32'd3);
    exp_tok("t1_tok0", 0, 0, 4);
    exp_tok("t1_tok1", 1, 1, 5);
    exp_tok("t1_tok2", 2, 0, 6);
    chk("t1_empty", 32'(tok_valid), 32'd0);

    // Saturate-and-split on the 3-bit length instance.
    do_reset();
    repeat (10) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(3);
    chk("t2_ntok", 32'(log3_l.size()), 32'd3);
    exp_tok3("t2_tok0", 0, 1, 7);
    exp_tok3("t2_tok1", 1, 1, 3);
    exp_tok3("t2_tok2", 2, 0, 1);
    exp_tok("t2_wide0", 0, 1, 10);

    // Overflow: consumer stalled, five tokens into a four-entry FIFO.
    do_reset();
    tok_ready = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'(i % 2), 1'b0);
    idle(1);
    chk("t3_count", 32'(fifo_count), 32'd4);
    chk("t3_head_level", 32'(tok_level), 32'd0);
    chk("t3_head_len", 32'(tok_len), 32'd1);
`ifdef WEIGHTED_RUN_OVERFLOW_EN
    chk("t3_ovf", 32'(ovf), 32'd1);
`endif
    tok_ready = 1'b1;
    idle(5);
    chk("t3_ntok", 32'(log_l.size()), 32'd4);
    exp_tok("t3_tok0", 0, 0, 1);
    exp_tok("t3_tok1", 1, 1, 1);
    exp_tok("t3_tok2", 2, 0, 1);
    exp_tok("t3_tok3", 3, 1, 1);

    // Push and pop together while full.
    do_reset();
    tok_ready = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'(i % 2), 1'b0);
    chk("t4_full", 32'(fifo_count), 32'd4);
    tok_ready = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    chk("t4_count", 32'(fifo_count), 32'd4);
`ifdef WEIGHTED_RUN_OVERFLOW_EN
    chk("t4_ovf", 32'(ovf), 32'd0);
`endif
    idle(6);
    chk("t4_ntok", 32'(log_l.size()), 32'd5);
    exp_tok("t4_tok4", 4, 0, 1);

    // flush with in_valid is ignored; lone flush emits.
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("t5_noflush", 32'(tok_valid), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    chk("t5_ntok", 32'(log_l.size()), 32'd1);
    exp_tok("t5_tok0", 0, 1, 3);

    // Reset mid-run discards the open run.
    do_reset();
    repeat (3) step(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("t6_valid", 32'(tok_valid), 32'd0);
    chk("t6_len", 32'(tok_len), 32'd0);
    chk("t6_count", 32'(fifo_count), 32'd0);
    clear_logs();
    repeat (2) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    chk("t6_ntok", 32'(log_l.size()), 32'd1);
    exp_tok("t6_tok0", 0, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
